// File: rtl/sdram_cmd_monitor_pkg.sv
// sdram_cmd_monitor_pkg: command, error and state encodings plus the init-step matcher.
package sdram_cmd_monitor_pkg;
  localparam int MIN_GAP = 8;
  typedef enum logic [2:0] {
    MRST = 3'b000, ARSR = 3'b001, PRCH = 3'b010, ACTV = 3'b011,
    WRTE = 3'b100, READ = 3'b101, BTRM = 3'b110, NOOP = 3'b111
  } cmd_t;
  typedef enum logic [3:0] {
    E_NONE = 4'd0, E_CKE_CMD = 4'd1, E_SEQ = 4'd2, E_GAP = 4'd3,
    E_DBL_ACTV = 4'd4, E_CLOSED = 4'd5, E_OPEN_REF = 4'd6, E_CKE_DROP = 4'd7
  } err_t;
  typedef enum logic [3:0] {
    S_PWRUP, S_PALL1, S_EMRS, S_MRS_DLL, S_PALL2, S_REF1, S_REF2, S_MRS, S_READY, S_ERROR
  } state_t;
  // init states are ordered so a match always advances to state + 1
  function automatic logic init_match(state_t s, cmd_t c, logic [1:0] b, logic [12:0] a);
    case (s)
      S_PALL1, S_PALL2: return c == PRCH && a[10];
      S_EMRS:           return c == MRST && b == 2'd1;
      S_MRS_DLL:        return c == MRST && b == 2'd0 && a[8];
      S_REF1, S_REF2:   return c == ARSR;
      S_MRS:            return c == MRST && b == 2'd0 && !a[8];
      default:          return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/sdram_cmd_monitor_if.sv
// sdram_cmd_monitor_if: SDRAM command-bus pins as seen by driver (master) and monitor (slave).
interface sdram_cmd_monitor_if;
  logic        CKE;
  logic [2:0]  COMMAND;
  logic [12:0] ADDRESS;
  logic [1:0]  BANK;
  modport master (output CKE, COMMAND, ADDRESS, BANK);
  modport slave  (input CKE, COMMAND, ADDRESS, BANK);
endinterface

// File: rtl/sdram_bank_tracker.sv
// sdram_bank_tracker: per-bank open-row flags updated by ACTV/PRCH, with open/closed queries.
module sdram_bank_tracker
  import sdram_cmd_monitor_pkg::*;
(
  input  logic       CLK_n,
  input  logic       RST,
  input  logic       en,
  input  cmd_t       cmd,
  input  logic [1:0] bank,
  input  logic       a10,
  output logic [3:0] bank_open,
  output logic       sel_open,
  output logic       any_open
);
  always_ff @(posedge CLK_n or negedge RST)
    if (!RST) bank_open <= 4'b0;
    else if (en) bank_open <= cmd == ACTV ? bank_open | (4'b1 << bank) :
                              cmd == PRCH ? (a10 ? 4'b0 : bank_open & ~(4'b1 << bank)) : bank_open;
  assign sel_open = bank_open[bank];
  assign any_open = |bank_open;
endmodule

// File: rtl/sdram_cmd_monitor.sv
// sdram_cmd_monitor: checks SDRAM init sequence, bank usage and refreshes; sticky first error.
// Define SDRAM_MON_GAP_CHECK_EN to enable the init NOOP-gap counter and error 3.
module sdram_cmd_monitor
  import sdram_cmd_monitor_pkg::*;
(
  input  logic                CLK_n,
  input  logic                RST,
  sdram_cmd_monitor_if.slave  bus,
  output logic                INIT_DONE,
  output logic                ERROR,
  output logic [3:0]          ERR_CODE,
  output logic [12:0]         MODE_REG,
  output logic [12:0]         EXT_MODE_REG,
  output logic [3:0]          BANK_OPEN,
  output logic [15:0]         REFRESH_COUNT
);
  state_t state, state_nx;
  err_t   err;
  cmd_t   cmd;
  logic   gap_short, sel_open, any_open, trk_en, in_init, ready, match;
  assign cmd = cmd_t'(bus.COMMAND);
`ifdef SDRAM_MON_GAP_CHECK_EN
  logic [7:0] gap;
  always_ff @(posedge CLK_n or negedge RST)
    if (!RST) gap <= 8'hff;
    else gap <= cmd != NOOP ? 8'h00 : gap == 8'hff ? gap : gap + 8'd1;
  assign gap_short = gap < 8'(MIN_GAP);
`else
  assign gap_short = 1'b0;
`endif
  always_comb begin
    ready = state == S_READY;
    in_init = state >= S_PALL1 && state <= S_MRS;
    match = init_match(state, cmd, bus.BANK, bus.ADDRESS);
    err = !bus.CKE && cmd != NOOP                                   ? E_CKE_CMD  :
          ready && !bus.CKE                                         ? E_CKE_DROP :
          in_init && cmd != NOOP && !match                          ? E_SEQ      :
          in_init && match && gap_short                             ? E_GAP      :
          ready && cmd == ACTV && sel_open                          ? E_DBL_ACTV :
          ready && (cmd == READ || cmd == WRTE) && !sel_open        ? E_CLOSED   :
          ready && (cmd == MRST || cmd == ARSR) && any_open         ? E_OPEN_REF : E_NONE;
    state_nx = state == S_ERROR || err != E_NONE ? S_ERROR :
               state == S_PWRUP                  ? (bus.CKE ? S_PALL1 : S_PWRUP) :
               in_init && match                  ? state_t'(state + 4'd1) : state;
    trk_en = ready && err == E_NONE;
  end
  sdram_bank_tracker u_trk (
    .CLK_n(CLK_n), .RST(RST), .en(trk_en), .cmd(cmd), .bank(bus.BANK),
    .a10(bus.ADDRESS[10]), .bank_open(BANK_OPEN), .sel_open(sel_open), .any_open(any_open)
  );
  // mode registers capture even on the violating cycle; everything freezes once in S_ERROR
  always_ff @(posedge CLK_n or negedge RST)
    if (!RST) begin
      state <= S_PWRUP;
      INIT_DONE <= 1'b0;
      ERROR <= 1'b0;
      ERR_CODE <= 4'd0;
      MODE_REG <= 13'd0;
      EXT_MODE_REG <= 13'd0;
      REFRESH_COUNT <= 16'd0;
    end else if (state != S_ERROR) begin
      state <= state_nx;
      INIT_DONE <= INIT_DONE | (state_nx == S_READY);
      ERROR <= err != E_NONE;
      ERR_CODE <= err;
      if (cmd == MRST && bus.BANK == 2'd0) MODE_REG <= bus.ADDRESS;
      if (cmd == MRST && bus.BANK == 2'd1) EXT_MODE_REG <= bus.ADDRESS;
      if (trk_en && cmd == ARSR) REFRESH_COUNT <= REFRESH_COUNT + 16'd1;
    end
endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// tb_sdram_cmd_monitor: directed scoreboard bench for the SDRAM command monitor.
module tb_sdram_cmd_monitor;
  import sdram_cmd_monitor_pkg::*;
  logic CLK_n = 1'b0, RST = 1'b0;
  logic INIT_DONE, ERROR;
  logic [3:0] ERR_CODE, BANK_OPEN;
  logic [12:0] MODE_REG, EXT_MODE_REG;
  logic [15:0] REFRESH_COUNT;
  sdram_cmd_monitor_if bus ();
  sdram_cmd_monitor dut (
    .CLK_n(CLK_n), .RST(RST), .bus(bus.slave), .INIT_DONE(INIT_DONE), .ERROR(ERROR),
    .ERR_CODE(ERR_CODE), .MODE_REG(MODE_REG), .EXT_MODE_REG(EXT_MODE_REG),
    .BANK_OPEN(BANK_OPEN), .REFRESH_COUNT(REFRESH_COUNT)
  );
  always #5 CLK_n = ~CLK_n;
  typedef struct { string tag; logic [51:0] v; } exp_t;
  exp_t sb[$];
  int total = 0, passed = 0;
  logic m_id, m_er;
  logic [3:0] m_code, m_bo;
  logic [12:0] m_mr, m_emr;
  logic [15:0] m_rc;
  cmd_t ic[7] = '{PRCH, MRST, MRST, PRCH, ARSR, ARSR, MRST};
  logic [1:0] ib[7] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [12:0] ia[7] = '{13'h400, 13'h000, 13'h131, 13'h400, 13'h000, 13'h000, 13'h031};

  task automatic push(string tag);
    exp_t e;
    e.tag = tag;
    e.v = {m_id, m_er, m_code, m_mr, m_emr, m_bo, m_rc};
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    logic [51:0] g;
    e = sb.pop_front();
    g = {INIT_DONE, ERROR, ERR_CODE, MODE_REG, EXT_MODE_REG, BANK_OPEN, REFRESH_COUNT};
    total++;
    assert (g === e.v) passed++;
    else $error("FAIL %s: got id=%b err=%b code=%0d mr=%h emr=%h bo=%b rc=%h, expected id=%b err=%b code=%0d mr=%h emr=%h bo=%b rc=%h",
                e.tag, g[51], g[50], g[49:46], g[45:33], g[32:20], g[19:16], g[15:0],
                e.v[51], e.v[50], e.v[49:46], e.v[45:33], e.v[32:20], e.v[19:16], e.v[15:0]);
  endtask
  task automatic drv(cmd_t c, logic [1:0] b, logic [12:0] a);
    bus.COMMAND = c;
    bus.BANK = b;
    bus.ADDRESS = a;
    @(negedge CLK_n);
  endtask
  task automatic issue(string tag, cmd_t c, logic [1:0] b, logic [12:0] a);
    push(tag);
    drv(c, b, a);
    check();
  endtask
  task automatic noops(int n);
    repeat (n) drv(NOOP, 2'd0, 13'd0);
  endtask
  task automatic do_reset();
    RST = 1'b0;
    bus.CKE = 1'b0;
    bus.COMMAND = NOOP;
    bus.BANK = 2'd0;
    bus.ADDRESS = 13'd0;
    {m_id, m_er, m_code, m_mr, m_emr, m_bo, m_rc} = '0;
    repeat (2) @(negedge CLK_n);
    RST = 1'b1;
    @(negedge CLK_n);
  endtask
  task automatic pwrup(int n);
    bus.CKE = 1'b0;
    noops(n);
    bus.CKE = 1'b1;
    noops(1);
  endtask
  task automatic init_steps(int from, int to, int gap);
    for (int i = from; i < to; i++) begin
      noops(gap);
      drv(ic[i], ib[i], ia[i]);
    end
  endtask
  task automatic full_init();
    pwrup(20);
    init_steps(0, 7, 15);
    noops(2);
    m_id = 1'b1;
    m_mr = 13'h031;
  endtask

  initial begin
    // reset, power-up and the full init sequence
    do_reset();
    issue("reset", NOOP, 2'd0, 13'd0);
    pwrup(256);
    issue("pwrup", NOOP, 2'd0, 13'd0);
    init_steps(0, 2, 15);
    noops(15);
    m_mr = 13'h131;
    issue("mrs_dll", MRST, 2'd0, 13'h131);
    init_steps(3, 6, 15);
    noops(14);
    issue("pre_done", NOOP, 2'd0, 13'd0);
    m_id = 1'b1;
    m_mr = 13'h031;
    issue("init_done", MRST, 2'd0, 13'h031);

    // command while CKE is low
    do_reset();
    m_er = 1'b1; m_code = 4'd1;
    issue("cke_cmd", ACTV, 2'd0, 13'd0);

    // ARSR where the EMR write is expected, then frozen outputs
    do_reset();
    pwrup(4);
    init_steps(0, 1, 15);
    noops(15);
    m_er = 1'b1; m_code = 4'd2;
    issue("seq", ARSR, 2'd0, 13'd0);
    issue("seq_frozen", MRST, 2'd0, 13'h055);

    // short gap before the EMR write; capture happens either way
    do_reset();
    pwrup(4);
    drv(PRCH, 2'd0, 13'h400);
    noops(3);
    m_emr = 13'h002;
`ifdef SDRAM_MON_GAP_CHECK_EN
    m_er = 1'b1; m_code = 4'd3;
`endif
    issue("gap", MRST, 2'd1, 13'h002);

    // async reset mid-init, then a clean full init and a double ACTV
    do_reset();
    pwrup(4);
    init_steps(0, 1, 15);
    noops(15);
    drv(MRST, 2'd1, 13'h002);
    noops(3);
    m_emr = 13'h002;
    issue("emrs", NOOP, 2'd0, 13'd0);
    #2 RST = 1'b0;
    #1;
    {m_id, m_er, m_code, m_mr, m_emr, m_bo, m_rc} = '0;
    push("async_rst");
    check();
    do_reset();
    full_init();
    issue("clean_init", NOOP, 2'd0, 13'd0);
    m_bo = 4'b0010;
    issue("actv1", ACTV, 2'd1, 13'd0);
    m_er = 1'b1; m_code = 4'd4;
    issue("dbl_actv", ACTV, 2'd1, 13'd0);

    // open bank 2, write it, read closed bank 1
    do_reset();
    full_init();
    m_bo = 4'b0100;
    issue("actv2", ACTV, 2'd2, 13'd0);
    issue("wrte2", WRTE, 2'd2, 13'd0);
    m_er = 1'b1; m_code = 4'd5;
    issue("read_closed", READ, 2'd1, 13'd0);
    issue("closed_frozen", ACTV, 2'd3, 13'd0);

    // precharge variants, refreshes, refresh with an open bank
    do_reset();
    full_init();
    m_bo = 4'b0001;
    issue("actv0", ACTV, 2'd0, 13'd0);
    m_bo = 4'b0000;
    issue("pall", PRCH, 2'd0, 13'h400);
    drv(ACTV, 2'd1, 13'd0);
    m_bo = 4'b1010;
    issue("actv3", ACTV, 2'd3, 13'd0);
    m_bo = 4'b1000;
    issue("prch1", PRCH, 2'd1, 13'd0);
    issue("prch1_closed", PRCH, 2'd1, 13'd0);
    m_bo = 4'b0000;
    issue("pall2", PRCH, 2'd2, 13'h400);
    for (int i = 1; i <= 3; i++) begin
      m_rc = 16'(i);
      issue("arsr", ARSR, 2'd0, 13'd0);
    end
    m_bo = 4'b0001;
    issue("actv0b", ACTV, 2'd0, 13'd0);
    m_er = 1'b1; m_code = 4'd6;
    issue("arsr_open", ARSR, 2'd0, 13'd0);

    // mode write in ready, refresh wrap, CKE drop
    do_reset();
    full_init();
    m_mr = 13'h021;
    issue("mrs_ready", MRST, 2'd0, 13'h021);
    issue("mrs_bank2", MRST, 2'd2, 13'h1ff);
    repeat (65534) drv(ARSR, 2'd0, 13'd0);
    m_rc = 16'hffff;
    issue("rc_max", ARSR, 2'd0, 13'd0);
    m_rc = 16'h0000;
    issue("rc_wrap", ARSR, 2'd0, 13'd0);
    bus.CKE = 1'b0;
    m_er = 1'b1; m_code = 4'd7;
    issue("cke_drop", NOOP, 2'd0, 13'd0);
    bus.CKE = 1'b1;
    issue("drop_frozen", ARSR, 2'd0, 13'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_monitor.md
# sdram_cmd_monitor

Device-side monitor for the DDR SDRAM command bus, sitting on the same pins the controller/initializer drives (CKE, command, address, bank). It decodes every sampled command, checks the power-up initialization sequence and its inter-command spacing, then tracks bank open/closed state and refreshes during normal operation. It captures mode/extended-mode register values and reports the first protocol violation with a sticky error code; it is synthesizable and usable both in the bench and as on-chip debug logic.

## Interface
- MIN_GAP, 8, minimum NOOP cycles required between two non-NOOP commands during initialization
- CLK_n  input  1  clock; all sampling on posedge CLK_n
- RST  input  1  reset, asynchronous, active-low
- CKE  input  1  clock enable as driven to the SDRAM
- COMMAND  input  3  {RAS_n,CAS_n,WE_n} as driven to the SDRAM
- ADDRESS  input  13  address pins
- BANK  input  2  bank-address pins
- INIT_DONE  output  1  initialization sequence completed correctly
- ERROR  output  1  sticky violation flag
- ERR_CODE  output  4  code of the first violation
- MODE_REG  output  13  last ADDRESS written with MRST, BANK=0
- EXT_MODE_REG  output  13  last ADDRESS written with MRST, BANK=1
- BANK_OPEN  output  4  bit n set while bank n has an active row
- REFRESH_COUNT  output  16  ARSR commands seen after INIT_DONE, wraps

## Operation
- Commands: NOOP=111, ACTV=011, READ=101, WRTE=100, BTRM=110, PRCH=010, ARSR=001, MRST=000.
- States: S_PWRUP, S_PALL1, S_EMRS, S_MRS_DLL, S_PALL2, S_REF1, S_REF2, S_MRS, S_READY, S_ERROR.
- S_PWRUP: non-NOOP while CKE=0 -> error 1; CKE rising -> S_PALL1.
- Init sequence, each expected step advances on match: PRCH A10=1; MRST BANK=1; MRST BANK=0 A8=1; PRCH A10=1; ARSR; ARSR; MRST BANK=0 A8=0 -> S_READY, INIT_DONE=1.
- During init: NOOP always legal; any other non-matching command -> error 2.
- Gap counter: 8-bit, cleared on non-NOOP, +1 per NOOP, saturates 255, starts saturated at reset. Matching init command with counter < MIN_GAP -> error 3.
- S_READY: ACTV sets BANK_OPEN[BANK]; ACTV to open bank -> error 4. READ/WRTE to closed bank -> error 5. PRCH A10=1 clears all, A10=0 clears BANK_OPEN[BANK]; PRCH to closed bank legal. MRST or ARSR with any bank open -> error 6. ARSR otherwise increments REFRESH_COUNT. BTRM, NOOP ignored. CKE=0 in S_READY -> error 7.
- MRST BANK 0/1 updates MODE_REG/EXT_MODE_REG in any non-error state, including when it is the violating command (capture precedes check). BANK 2/3 ignored.
- Error codes: 0 none, 1 cmd with CKE low, 2 out-of-sequence, 3 gap, 4 double ACTV, 5 access to closed bank, 6 MRST/ARSR with open bank, 7 CKE dropped after init.
- On any error: ERROR=1, ERR_CODE latched, go to S_ERROR; stays until RST. All other outputs freeze. INIT_DONE keeps its value.

## Timing
- All outputs registered; update on the posedge after the command is sampled (1-cycle latency).
- Reset values: INIT_DONE 0, ERROR 0, ERR_CODE 0, MODE_REG 0, EXT_MODE_REG 0, BANK_OPEN 0, REFRESH_COUNT 0; state S_PWRUP; gap counter 255.
- RST asserted mid-sequence clears everything asynchronously; monitoring restarts at S_PWRUP.
- One command per cycle, so at most one error condition per cycle; fixed check order 1,7,2,3,4,5,6 if encodings overlap.
- REFRESH_COUNT wraps 0xFFFF -> 0x0000 without error.

## Configuration
- SDRAM_MON_GAP_CHECK_EN: defined -> gap counter and error 3 present. Undefined -> counter removed, gap never checked, code 3 never produced; all else identical.

## Structure
- Shared package/header: command encodings (`NOOP, `ACTV, `READ, `WRTE, `BTRM, `PRCH, `ARSR, `MRST), error-code constants, state encodings.
- One sub-module: sdram_bank_tracker (BANK_OPEN flags, ACTV/PRCH update, open/closed queries for errors 4/5/6).

## Test plan
- CKE low 256 cycles, then exact init sequence, 15 NOOPs between commands -> INIT_DONE=1 one cycle after final MRST, MODE_REG=0x031, EXT_MODE_REG=0x000, ERROR=0.
- Init with ARSR issued where the EMR MRST is expected -> ERROR=1, ERR_CODE=2, INIT_DONE stays 0.
- Gap check enabled, MIN_GAP=8, only 3 NOOPs before second command -> ERR_CODE=3; same stimulus with macro undefined -> no error.
- After init: ACTV bank 2, WRTE bank 2, READ bank 1 -> BANK_OPEN=0100, then ERR_CODE=5.
- After init: ACTV bank 0, PRCH A10=1, ARSR x3 -> BANK_OPEN=0000, REFRESH_COUNT=3; then ACTV bank 0, ARSR -> ERR_CODE=6.
- RST low mid-init (after EMRS), release, full sequence -> clean INIT_DONE=1, all counters from reset values.
